ma_stage: RTL and testbench

Memory-access pipeline stage directly downstream of the execution stage. It consumes the EX→MA pipeline register (address/result, store data, load/store code) and issues at most one data-memory transaction per instruction over a req/gnt/rvalid bus. It also aligns store data, sign/zero-extends load data and registers the writeback result into two WB pipeline slots used for writeback and forwarding. It requests a pipeline stall while a memory transaction is outstanding.

---
 rtl/ma_stage_pkg.sv | 17 +
 rtl/ma_stage_ldst_align.sv | 47 ++++
 rtl/ma_stage.sv | 146 ++++++++++++++
 tb/tb_ma_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ma_stage_pkg.sv
// Shared definitions for the memory-access stage: load/store codes and FSM encoding.
package ma_stage_pkg;

   localparam logic [2:0] LDST_B  = 3'b000;
   localparam logic [2:0] LDST_H  = 3'b001;
   localparam logic [2:0] LDST_W  = 3'b010;
   localparam logic [2:0] LDST_BU = 3'b100;
   localparam logic [2:0] LDST_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RESP  = 2'd1,
      DONE  = 2'd2,
      FLUSH = 2'd3
   } ma_state_e;

endpackage

// File: rtl/ma_stage_ldst_align.sv
// Combinational lane alignment: store byte enables/data, load extraction and
// sign/zero extension, and misalignment detection.
module ldst_align
   import ma_stage_pkg::*;
(
   input  logic [2:0]  code,
   input  logic [1:0]  adr,
   input  logic [31:0] st_data,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] ext_data,
   output logic        misaligned
);

   logic [31:0] lane;
   logic [15:0] half;
   logic        zext;

   always_comb begin
      be         = 4'b1111;
      wdata      = st_data;
      ext_data   = rdata;
      misaligned = 1'b0;
      lane       = rdata >> {adr, 3'b000};
      half       = adr[1] ? rdata[31:16] : rdata[15:0];
      zext       = (code == LDST_BU) || (code == LDST_HU);
      // Access size comes from the low two bits; 011/110/111 fall through to word.
      case (code[1:0])
         LDST_B[1:0]: begin
            be       = 4'b0001 << adr;
            wdata    = {4{st_data[7:0]}};
            ext_data = zext ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
         end
         LDST_H[1:0]: begin
            misaligned = adr[0];
            be         = adr[1] ? 4'b1100 : 4'b0011;
            wdata      = {2{st_data[15:0]}};
            ext_data   = zext ? {16'h0, half} : {{16{half[15]}}, half};
         end
         default: begin
            misaligned = |adr;
         end
      endcase
   end

endmodule

// File: rtl/ma_stage.sv
// Memory-access pipeline stage: issues one data-memory transaction per ld/st,
// stalls while it is outstanding, and registers two writeback slots.
module ma_stage
   import ma_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_ld_ma,
   input  logic        cmd_st_ma,
   input  logic [4:0]  rd_adr_ma,
   input  logic [31:0] rd_data_ma,
   input  logic        wbk_rd_reg_ma,
   input  logic [31:0] st_data_ma,
   input  logic [2:0]  ldst_code_ma,
   input  logic        stall,
   input  logic        rst_pipe,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [29:0] dmem_adr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic        stall_ma,
   output logic        misalign_ma,
   output logic [4:0]  rd_adr_wb,
   output logic [31:0] wbk_data_wb,
   output logic        wbk_rd_reg_wb,
   output logic [4:0]  rd_adr_wb2,
   output logic [31:0] wbk_data_wb2,
   output logic        wbk_rd_reg_wb2
);

   ma_state_e   state, state_nxt;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic [31:0] ext_data;
   logic [31:0] ld_q;
   logic [31:0] res_data;
   logic        misaligned;
   logic        ldst;
   logic        access;
   logic        advance;
   logic        capture;
   logic        res_we;

   ldst_align u_align (
      .code       (ldst_code_ma),
      .adr        (rd_data_ma[1:0]),
      .st_data    (st_data_ma),
      .rdata      (dmem_rdata),
      .be         (st_be),
      .wdata      (st_wdata),
      .ext_data   (ext_data),
      .misaligned (misaligned)
   );

   assign ldst   = cmd_ld_ma | cmd_st_ma;
   assign access = ldst & ~misaligned & ~rst_pipe & rst_n;

   assign dmem_we    = cmd_st_ma;
   assign dmem_adr   = rd_data_ma[31:2];
   assign dmem_be    = cmd_ld_ma ? 4'b1111 : st_be;
   assign dmem_wdata = st_wdata;

   always_comb begin
      state_nxt = state;
      dmem_req  = 1'b0;
      stall_ma  = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            dmem_req = access;
            stall_ma = access & ~(cmd_st_ma & dmem_gnt);
            if (access && dmem_gnt) begin
               if (cmd_st_ma) begin
                  if (stall) state_nxt = DONE;
               end else begin
                  state_nxt = RESP;
               end
            end
         end
         RESP: begin
            stall_ma = ~dmem_rvalid;
            // A response arriving with the flush is simply dropped; otherwise wait for it in FLUSH.
            if (rst_pipe) begin
               state_nxt = dmem_rvalid ? IDLE : FLUSH;
            end else if (dmem_rvalid) begin
               capture   = 1'b1;
               state_nxt = stall ? DONE : IDLE;
            end
         end
         DONE: begin
            if (rst_pipe || !stall) state_nxt = IDLE;
         end
         FLUSH: begin
            stall_ma = 1'b1;
            if (dmem_rvalid) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign advance     = ~stall & ~stall_ma & ~rst_pipe;
   assign misalign_ma = (state == IDLE) & ldst & misaligned & advance & rst_n;
   assign res_we      = wbk_rd_reg_ma & ~(ldst & misaligned);
   // Load data is taken live on rvalid, or from the capture register if the stage sat in DONE.
   assign res_data    = cmd_ld_ma ? ((state == DONE) ? ld_q : ext_data) : rd_data_ma;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ld_q  <= '0;
      end else begin
         state <= state_nxt;
         if (capture) ld_q <= ext_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_adr_wb      <= '0;
         wbk_data_wb    <= '0;
         wbk_rd_reg_wb  <= 1'b0;
         rd_adr_wb2     <= '0;
         wbk_data_wb2   <= '0;
         wbk_rd_reg_wb2 <= 1'b0;
      end else if (rst_pipe) begin
         rd_adr_wb      <= '0;
         wbk_data_wb    <= '0;
         wbk_rd_reg_wb  <= 1'b0;
         rd_adr_wb2     <= '0;
         wbk_data_wb2   <= '0;
         wbk_rd_reg_wb2 <= 1'b0;
      end else if (advance) begin
         rd_adr_wb      <= rd_adr_ma;
         wbk_data_wb    <= res_data;
         wbk_rd_reg_wb  <= res_we;
         rd_adr_wb2     <= rd_adr_wb;
         wbk_data_wb2   <= wbk_data_wb;
         wbk_rd_reg_wb2 <= wbk_rd_reg_wb;
      end
   end

endmodule

// File: tb/tb_ma_stage.sv
// Bench for ma_stage: vector table driven through a bench-side memory responder,
// writeback results checked through a scoreboard queue, plus reset and flush sequences.
module tb_ma_stage;
   import ma_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_ld_ma, cmd_st_ma, wbk_rd_reg_ma, stall, rst_pipe;
   logic [4:0]  rd_adr_ma;
   logic [31:0] rd_data_ma, st_data_ma;
   logic [2:0]  ldst_code_ma;
   logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
   logic [29:0] dmem_adr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata, dmem_rdata;
   logic        stall_ma, misalign_ma;
   logic [4:0]  rd_adr_wb, rd_adr_wb2;
   logic [31:0] wbk_data_wb, wbk_data_wb2;
   logic        wbk_rd_reg_wb, wbk_rd_reg_wb2;

   ma_stage dut (
      .clk(clk), .rst_n(rst_n), .cmd_ld_ma(cmd_ld_ma), .cmd_st_ma(cmd_st_ma),
      .rd_adr_ma(rd_adr_ma), .rd_data_ma(rd_data_ma), .wbk_rd_reg_ma(wbk_rd_reg_ma),
      .st_data_ma(st_data_ma), .ldst_code_ma(ldst_code_ma), .stall(stall),
      .rst_pipe(rst_pipe), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_adr(dmem_adr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
      .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .stall_ma(stall_ma),
      .misalign_ma(misalign_ma), .rd_adr_wb(rd_adr_wb), .wbk_data_wb(wbk_data_wb),
      .wbk_rd_reg_wb(wbk_rd_reg_wb), .rd_adr_wb2(rd_adr_wb2), .wbk_data_wb2(wbk_data_wb2),
      .wbk_rd_reg_wb2(wbk_rd_reg_wb2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ld;
      logic        st;
      logic [2:0]  code;
      logic [31:0] adr;
      logic [31:0] sdata;
      logic [31:0] rdata;
      logic [4:0]  rd;
      logic        wbk;
      int          gnt_dly;
      int          rv_dly;
      int          stall_cyc;
      int          exp_gnt;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic [31:0] exp_data;
      logic        exp_we;
      int          exp_mis;
      int          exp_stall;
      logic        chk;
   } vec_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        we;
      logic        chk;
   } wb_t;

   int   n_chk = 0;
   int   n_err = 0;
   wb_t  sb[$];
   wb_t  prev;
   vec_t vecs[16];
   vec_t fresh;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, got, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      wb_t e;
      int  cyc, n_gnt, n_late, n_stall, n_mis, gcyc;
      bit  granted, done;
      string tag;
      tag = $sformatf("v%0d", idx);
      cmd_ld_ma = v.ld; cmd_st_ma = v.st; ldst_code_ma = v.code;
      rd_data_ma = v.adr; st_data_ma = v.sdata; rd_adr_ma = v.rd; wbk_rd_reg_ma = v.wbk;
      sb.push_back('{rd: v.rd, data: v.exp_data, we: v.exp_we, chk: v.chk});
      cyc = 0; n_gnt = 0; n_late = 0; n_stall = 0; n_mis = 0; gcyc = 0;
      granted = 1'b0; done = 1'b0;
      while (!done && cyc < 40) begin
         stall = (cyc < v.stall_cyc);
         dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = ~v.rdata;
         #1;
         if (dmem_req) begin
            if (granted) n_late++;
            else if (cyc >= v.gnt_dly) begin
               dmem_gnt = 1'b1; granted = 1'b1; gcyc = cyc; n_gnt++;
               chk({tag, "_we"}, dmem_we, v.st);
               chk({tag, "_adr"}, dmem_adr, v.adr[31:2]);
               chk({tag, "_be"}, dmem_be, v.exp_be);
               if (v.st) chk({tag, "_wdata"}, dmem_wdata, v.exp_wdata);
            end
         end
         if (v.ld && granted && cyc == gcyc + v.rv_dly) begin
            dmem_rvalid = 1'b1; dmem_rdata = v.rdata;
         end
         #1;
         if (misalign_ma) n_mis++;
         if (stall_ma) n_stall++;
         else if (!stall) done = 1'b1;
         cyc++;
         @(negedge clk);
      end
      if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; stall = 1'b0;
      #1;
      chk({tag, "_ngnt"}, n_gnt, v.exp_gnt);
      chk({tag, "_reissue"}, n_late, 0);
      chk({tag, "_stallcyc"}, n_stall, v.exp_stall);
      chk({tag, "_misalign"}, n_mis, v.exp_mis);
      e = sb.pop_front();
      chk({tag, "_wb_rd"}, rd_adr_wb, e.rd);
      chk({tag, "_wb_we"}, wbk_rd_reg_wb, e.we);
      if (e.chk) chk({tag, "_wb_data"}, wbk_data_wb, e.data);
      chk({tag, "_wb2_rd"}, rd_adr_wb2, prev.rd);
      chk({tag, "_wb2_we"}, wbk_rd_reg_wb2, prev.we);
      if (prev.chk) chk({tag, "_wb2_data"}, wbk_data_wb2, prev.data);
      prev = e;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //          ld st code    adr            sdata          rdata          rd    wbk gd rv sc  g  be       wdata          data           we mis st chk
      vecs[0]  = '{0, 1, 3'b010, 32'h100,      32'hDEADBEEF, 32'h0,         5'd0,  0, 0, 0, 0, 1, 4'b1111, 32'hDEADBEEF, 32'h100,       0, 0, 0, 1};
      vecs[1]  = '{0, 1, 3'b000, 32'h103,      32'h000000A5, 32'h0,         5'd1,  0, 0, 0, 0, 1, 4'b1000, 32'hA5A5A5A5, 32'h103,       0, 0, 0, 1};
      vecs[2]  = '{1, 0, 3'b000, 32'h202,      32'h0,        32'h1280FF00,  5'd5,  1, 0, 1, 0, 1, 4'b1111, 32'h0,        32'hFFFFFF80,  1, 0, 1, 1};
      vecs[3]  = '{1, 0, 3'b101, 32'h202,      32'h0,        32'h80011234,  5'd6,  1, 0, 3, 0, 1, 4'b1111, 32'h0,        32'h00008001,  1, 0, 3, 1};
      vecs[4]  = '{1, 0, 3'b010, 32'h101,      32'h0,        32'h11111111,  5'd7,  1, 0, 1, 0, 0, 4'b1111, 32'h0,        32'h0,         0, 1, 0, 0};
      vecs[5]  = '{0, 1, 3'b001, 32'h12,       32'h12345678, 32'h0,         5'd8,  0, 2, 0, 0, 1, 4'b1100, 32'h56785678, 32'h12,        0, 0, 2, 1};
      vecs[6]  = '{1, 0, 3'b001, 32'h10,       32'h0,        32'h0000F00D,  5'd9,  1, 1, 2, 0, 1, 4'b1111, 32'h0,        32'hFFFFF00D,  1, 0, 3, 1};
      vecs[7]  = '{1, 0, 3'b100, 32'h3,        32'h0,        32'h9A000000,  5'd10, 1, 0, 1, 0, 1, 4'b1111, 32'h0,        32'h0000009A,  1, 0, 1, 1};
      vecs[8]  = '{1, 0, 3'b010, 32'h8,        32'h0,        32'hCAFEF00D,  5'd11, 1, 0, 1, 3, 1, 4'b1111, 32'h0,        32'hCAFEF00D,  1, 0, 1, 1};
      vecs[9]  = '{0, 1, 3'b000, 32'h1,        32'h00000077, 32'h0,         5'd12, 0, 0, 0, 2, 1, 4'b0010, 32'h77777777, 32'h1,         0, 0, 0, 1};
      vecs[10] = '{0, 0, 3'b001, 32'h12345679, 32'h0,        32'h0,         5'd13, 1, 0, 0, 0, 0, 4'b1111, 32'h0,        32'h12345679,  1, 0, 0, 1};
      vecs[11] = '{0, 1, 3'b001, 32'h7,        32'h0000FFFF, 32'h0,         5'd14, 1, 0, 0, 0, 0, 4'b0000, 32'h0,        32'h7,         0, 1, 0, 1};
      vecs[12] = '{1, 0, 3'b011, 32'h4,        32'h0,        32'h80000001,  5'd15, 1, 0, 1, 0, 1, 4'b1111, 32'h0,        32'h80000001,  1, 0, 1, 1};
      vecs[13] = '{1, 0, 3'b000, 32'h1,        32'h0,        32'h00007F00,  5'd16, 1, 0, 2, 0, 1, 4'b1111, 32'h0,        32'h0000007F,  1, 0, 2, 1};
      vecs[14] = '{0, 1, 3'b001, 32'h20,       32'h0000ABCD, 32'h0,         5'd18, 0, 0, 0, 0, 1, 4'b0011, 32'hABCDABCD, 32'h20,        0, 0, 0, 1};
      vecs[15] = '{0, 1, 3'b010, 32'h40,       32'h01020304, 32'h0,         5'd17, 0, 1, 0, 1, 1, 4'b1111, 32'h01020304, 32'h40,        0, 0, 1, 1};
      fresh    = '{1, 0, 3'b010, 32'h24,       32'h0,        32'h0BADF00D,  5'd3,  1, 0, 1, 0, 1, 4'b1111, 32'h0,        32'h0BADF00D,  1, 0, 1, 1};
      prev = '{rd: 5'd0, data: 32'h0, we: 1'b0, chk: 1'b1};

      // Reset with an aligned load presented: nothing may be requested.
      rst_n = 1'b0; rst_pipe = 1'b0; stall = 1'b0;
      cmd_ld_ma = 1'b1; cmd_st_ma = 1'b0; ldst_code_ma = LDST_W; rd_data_ma = 32'h0;
      st_data_ma = 32'h0; rd_adr_ma = 5'd4; wbk_rd_reg_ma = 1'b1;
      dmem_gnt = 1'b1; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk("rst_req", dmem_req, 0);
      chk("rst_stall", stall_ma, 0);
      chk("rst_misalign", misalign_ma, 0);
      chk("rst_wb_we", wbk_rd_reg_wb, 0);
      chk("rst_wb_data", wbk_data_wb, 0);
      chk("rst_wb_rd", rd_adr_wb, 0);
      chk("rst_wb2_data", wbk_data_wb2, 0);
      chk("rst_wb2_we", wbk_rd_reg_wb2, 0);
      cmd_ld_ma = 1'b0; wbk_rd_reg_ma = 1'b0; dmem_gnt = 1'b0; rd_adr_ma = 5'd0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

      // Flush while a load response is outstanding.
      cmd_ld_ma = 1'b1; cmd_st_ma = 1'b0; ldst_code_ma = LDST_W; rd_data_ma = 32'h20;
      rd_adr_ma = 5'd2; wbk_rd_reg_ma = 1'b1; stall = 1'b0;
      #1;
      chk("fl_issue_req", dmem_req, 1);
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0; cmd_ld_ma = 1'b0; wbk_rd_reg_ma = 1'b0; rst_pipe = 1'b1;
      #1;
      chk("fl_resp_stall", stall_ma, 1);
      chk("fl_resp_req", dmem_req, 0);
      @(negedge clk);
      rst_pipe = 1'b0;
      cmd_ld_ma = fresh.ld; rd_data_ma = fresh.adr; rd_adr_ma = fresh.rd; wbk_rd_reg_ma = fresh.wbk;
      dmem_rvalid = 1'b1; dmem_rdata = 32'h55555555;
      #1;
      chk("fl_flush_stall", stall_ma, 1);
      chk("fl_flush_req", dmem_req, 0);
      chk("fl_wb_we", wbk_rd_reg_wb, 0);
      chk("fl_wb_data", wbk_data_wb, 0);
      chk("fl_wb_rd", rd_adr_wb, 0);
      chk("fl_wb2_we", wbk_rd_reg_wb2, 0);
      chk("fl_wb2_data", wbk_data_wb2, 0);
      @(negedge clk);
      dmem_rvalid = 1'b0;
      prev = '{rd: 5'd0, data: 32'h0, we: 1'b0, chk: 1'b1};
      run_vec(99, fresh);

      cmd_ld_ma = 1'b0; cmd_st_ma = 1'b0; wbk_rd_reg_ma = 1'b0;
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
